// File: rtl/reveal_sequencer_if.sv
// reveal_sequencer_if
//   Bundles the game-side request/status signals and the board RAM port
//   of reveal_sequencer.
//   slave  : the sequencer side (takes requests and read data, drives the
//            board address/write port and status).
//   master : the environment side (game FSM plus board memory).
//   start / start_x / start_y : reveal request at cursor (x,y)
//   mem_addr / mem_rd_data    : board read port, {y,x} address, 1-cycle latency
//   mem_wr_en / mem_wr_data   : board write port (same address)
//   busy / done / result      : request status
//   cells_revealed            : cumulative count of cells written with a count
interface reveal_sequencer_if;
  logic       start;
  logic [2:0] start_x;
  logic [2:0] start_y;
  logic [5:0] mem_addr;
  logic [3:0] mem_rd_data;
  logic       mem_wr_en;
  logic [3:0] mem_wr_data;
  logic       busy;
  logic       done;
  logic [1:0] result;
  logic [6:0] cells_revealed;

  modport slave (
    input  start, start_x, start_y, mem_rd_data,
    output mem_addr, mem_wr_en, mem_wr_data, busy, done, result, cells_revealed
  );

  modport master (
    output start, start_x, start_y, mem_rd_data,
    input  mem_addr, mem_wr_en, mem_wr_data, busy, done, result, cells_revealed
  );
endinterface

// File: rtl/reveal_sequencer.sv
// reveal_sequencer
//   Reveals a cell of the 8x8 minesweeper board (4-bit cell codes) after a
//   select at (x,y): reads the target, and if it is hidden and safe writes
//   back its adjacent-bomb count. Cells waiting in the internal BFS queue are
//   marked 4'hE so that each is queued at most once.
//   Optional flood fill: define REVEAL_FLOOD_FILL_EN to keep revealing outward
//   from zero-count cells. Without it only the target cell is revealed.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : reveal_sequencer_if.slave (request, board RAM port, status)
module reveal_sequencer #(
  parameter int unsigned QUEUE_AW  = 6,
  parameter logic [3:0]  BOMB_CODE = 4'hB
) (
  input  logic               clk,
  input  logic               rst,
  reveal_sequencer_if.slave  bus
);

  localparam int unsigned QDEPTH = 2 ** QUEUE_AW;

  localparam logic [3:0] CELL_HIDDEN    = 4'hA;
  localparam logic [3:0] CELL_FLAG_BOMB = 4'hD;
  localparam logic [3:0] CELL_QUEUED    = 4'hE;

  localparam logic [1:0] RES_REVEALED = 2'b00;
  localparam logic [1:0] RES_BOMB     = 2'b01;
  localparam logic [1:0] RES_IGNORED  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD_TGT, CHK_TGT, POP, RD_NB, WR_CNT, SCAN, FIN
  } state_t;

  state_t r_state, w_state_nxt;

  logic [5:0]        r_tgt;
  logic [5:0]        r_cur;
  logic [1:0]        r_result;
  logic [6:0]        r_cells;
  logic [QUEUE_AW:0] r_wp, r_rp;
  logic [5:0]        r_q [QDEPTH];
  logic [7:0]        r_nb_vld;
  logic [3:0]        r_nb_data [8];
  logic [7:0]        r_issued;
  logic              r_pend_vld;
  logic [2:0]        r_pend_idx;
`ifdef REVEAL_FLOOD_FILL_EN
  logic [2:0]        r_scan_idx;
`endif

  logic [2:0] w_cur_x, w_cur_y, w_xm, w_xp, w_ym, w_yp;
  logic       w_xlo, w_xhi, w_ylo, w_yhi;
  logic [7:0] w_nb_inb;
  logic [5:0] w_nb_addr [8];
  logic [7:0] w_pend, w_issue_1h;
  logic       w_issue_found;
  logic [2:0] w_issue_idx;
  logic [3:0] w_count;
  logic       w_q_empty;
  logic [5:0] w_mem_addr;
  logic       w_mem_wr_en;
  logic [3:0] w_mem_wr_data;
  logic       w_push;
  logic [5:0] w_push_addr;
  logic       w_pop;
  logic       w_set_result;
  logic [1:0] w_result_nxt;

  // Neighbour table in visit order; 3-bit x-1/x+1 wrap is masked by w_nb_inb.
  always_comb begin
    w_cur_x = r_cur[2:0];
    w_cur_y = r_cur[5:3];
    w_xm = w_cur_x - 3'd1;
    w_xp = w_cur_x + 3'd1;
    w_ym = w_cur_y - 3'd1;
    w_yp = w_cur_y + 3'd1;
    w_xlo = (w_cur_x != 3'd0);
    w_xhi = (w_cur_x != 3'd7);
    w_ylo = (w_cur_y != 3'd0);
    w_yhi = (w_cur_y != 3'd7);
    w_nb_addr[0] = {w_ym, w_xm};    w_nb_inb[0] = w_xlo & w_ylo;
    w_nb_addr[1] = {w_ym, w_cur_x}; w_nb_inb[1] = w_ylo;
    w_nb_addr[2] = {w_ym, w_xp};    w_nb_inb[2] = w_xhi & w_ylo;
    w_nb_addr[3] = {w_cur_y, w_xm}; w_nb_inb[3] = w_xlo;
    w_nb_addr[4] = {w_cur_y, w_xp}; w_nb_inb[4] = w_xhi;
    w_nb_addr[5] = {w_yp, w_xm};    w_nb_inb[5] = w_xlo & w_yhi;
    w_nb_addr[6] = {w_yp, w_cur_x}; w_nb_inb[6] = w_yhi;
    w_nb_addr[7] = {w_yp, w_xp};    w_nb_inb[7] = w_xhi & w_yhi;
  end

  // Next neighbour to read: lowest in-bounds entry not yet issued, so
  // out-of-board neighbours cost no cycle.
  always_comb begin
    w_pend        = w_nb_inb & ~r_issued;
    w_issue_1h    = w_pend & (~w_pend + 8'd1);
    w_issue_found = |w_pend;
    w_issue_idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (w_issue_1h[k]) w_issue_idx = 3'(k);
    end
  end

  always_comb begin
    w_count = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (r_nb_vld[k] && (r_nb_data[k] == BOMB_CODE || r_nb_data[k] == CELL_FLAG_BOMB))
        w_count = w_count + 4'd1;
    end
  end

  assign w_q_empty = (r_wp == r_rp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mem_addr    = '0;
    w_mem_wr_en   = 1'b0;
    w_mem_wr_data = '0;
    w_push        = 1'b0;
    w_push_addr   = '0;
    w_pop         = 1'b0;
    w_set_result  = 1'b0;
    w_result_nxt  = RES_REVEALED;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_nxt = RD_TGT;
      end
      RD_TGT: begin
        w_mem_addr  = r_tgt;
        w_state_nxt = CHK_TGT;
      end
      CHK_TGT: begin
        w_mem_addr = r_tgt;
        if (bus.mem_rd_data == CELL_HIDDEN) begin
          w_mem_wr_en   = 1'b1;
          w_mem_wr_data = CELL_QUEUED;
          w_push        = 1'b1;
          w_push_addr   = r_tgt;
          w_state_nxt   = POP;
        end else if (bus.mem_rd_data == BOMB_CODE) begin
          w_set_result = 1'b1;
          w_result_nxt = RES_BOMB;
          w_state_nxt  = FIN;
        end else begin
          w_set_result = 1'b1;
          w_result_nxt = RES_IGNORED;
          w_state_nxt  = FIN;
        end
      end
      POP: begin
        if (w_q_empty) begin
          w_set_result = 1'b1;
          w_result_nxt = RES_REVEALED;
          w_state_nxt  = FIN;
        end else begin
          w_pop       = 1'b1;
          w_state_nxt = RD_NB;
        end
      end
      RD_NB: begin
        // Extra final cycle only captures the last outstanding read.
        if (w_issue_found) w_mem_addr = w_nb_addr[w_issue_idx];
        else               w_state_nxt = WR_CNT;
      end
      WR_CNT: begin
        w_mem_addr    = r_cur;
        w_mem_wr_en   = 1'b1;
        w_mem_wr_data = w_count;
`ifdef REVEAL_FLOOD_FILL_EN
        w_state_nxt   = (w_count == 4'd0) ? SCAN : POP;
`else
        w_state_nxt   = POP;
`endif
      end
`ifdef REVEAL_FLOOD_FILL_EN
      SCAN: begin
        if (r_nb_vld[r_scan_idx] && r_nb_data[r_scan_idx] == CELL_HIDDEN) begin
          w_mem_addr    = w_nb_addr[r_scan_idx];
          w_mem_wr_en   = 1'b1;
          w_mem_wr_data = CELL_QUEUED;
          w_push        = 1'b1;
          w_push_addr   = w_nb_addr[r_scan_idx];
        end
        if (r_scan_idx == 3'd7) w_state_nxt = POP;
      end
`endif
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt      <= '0;
      r_cur      <= '0;
      r_result   <= '0;
      r_cells    <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_nb_vld   <= '0;
      r_nb_data  <= '{default: '0};
      r_issued   <= '0;
      r_pend_vld <= 1'b0;
      r_pend_idx <= '0;
`ifdef REVEAL_FLOOD_FILL_EN
      r_scan_idx <= '0;
`endif
    end else begin
      if (w_push)       r_wp     <= r_wp + 1'b1;
      if (w_set_result) r_result <= w_result_nxt;
      if (w_pop) begin
        r_cur      <= r_q[r_rp[QUEUE_AW-1:0]];
        r_rp       <= r_rp + 1'b1;
        r_nb_vld   <= '0;
        r_issued   <= '0;
        r_pend_vld <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (bus.start) r_tgt <= {bus.start_y, bus.start_x};
        end
        RD_NB: begin
          if (r_pend_vld) begin
            r_nb_data[r_pend_idx] <= bus.mem_rd_data;
            r_nb_vld[r_pend_idx]  <= 1'b1;
          end
          r_issued   <= r_issued | w_issue_1h;
          r_pend_vld <= w_issue_found;
          r_pend_idx <= w_issue_idx;
        end
        WR_CNT: begin
          r_cells <= r_cells + 7'd1;
`ifdef REVEAL_FLOOD_FILL_EN
          r_scan_idx <= '0;
`endif
        end
`ifdef REVEAL_FLOOD_FILL_EN
        SCAN: begin
          r_scan_idx <= r_scan_idx + 3'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wp[QUEUE_AW-1:0]] <= w_push_addr;
  end

  assign bus.mem_addr       = w_mem_addr;
  assign bus.mem_wr_en      = w_mem_wr_en;
  assign bus.mem_wr_data    = w_mem_wr_data;
  assign bus.busy           = (r_state != IDLE) && (r_state != FIN);
  assign bus.done           = (r_state == FIN);
  assign bus.result         = r_result;
  assign bus.cells_revealed = r_cells;

endmodule

// File: tb/tb_reveal_sequencer.sv
// tb_reveal_sequencer
//   Self-checking bench for reveal_sequencer with a behavioural board RAM
//   (registered read, 1-cycle latency). Expected writes and results are
//   queued when a reveal is requested and matched against what the monitor
//   records. Flood-fill expectations follow REVEAL_FLOOD_FILL_EN.
module tb_reveal_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reveal_sequencer_if bus();

  reveal_sequencer #(.QUEUE_AW(6), .BOMB_CODE(4'hB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] mem [64];
  logic [3:0] img [64];
  logic       load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= img[i];
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wr_data;
    end
    bus.mem_rd_data <= mem[bus.mem_addr];
  end

  logic [9:0] obs_wr[$];
  logic [1:0] obs_res[$];
  logic [9:0] exp_wr[$];
  logic [1:0] exp_res[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_wr_en) obs_wr.push_back({bus.mem_addr, bus.mem_wr_data});
      if (bus.done)      obs_res.push_back(bus.result);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [3:0] nb_bombs(input int x, input int y);
    int c = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8)
          if (img[(y + dy) * 8 + x + dx] == 4'hB || img[(y + dy) * 8 + x + dx] == 4'hD) c++;
    return 4'(c);
  endfunction

  task automatic fill_img(input logic [3:0] v);
    for (int i = 0; i < 64; i++) img[i] = v;
  endtask

  task automatic load_board();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    obs_wr.delete(); obs_res.delete(); exp_wr.delete(); exp_res.delete();
  endtask

  // Issue one request and wait for done; lat counts cycles from acceptance.
  task automatic do_reveal(input logic [2:0] x, input logic [2:0] y,
                           output int lat, output int busy_cyc, output bit timed_out);
    @(negedge clk);
    bus.start = 1'b1; bus.start_x = x; bus.start_y = y;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1; busy_cyc = 0; timed_out = 1'b0;
    while (!bus.done) begin
      if (bus.busy) busy_cyc++;
      if (lat >= 4000) begin timed_out = 1'b1; break; end
      @(negedge clk); lat++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.start_x = '0; bus.start_y = '0; load_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", bus.done); else n_pass++;
    n_checks++; if (bus.result !== 2'b00) $display("FAIL reset_result: got %0b expected 00", bus.result); else n_pass++;
    n_checks++; if (bus.mem_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b expected 0", bus.mem_wr_en); else n_pass++;
    n_checks++; if (bus.mem_addr !== 6'd0) $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.mem_wr_data !== 4'h0) $display("FAIL reset_wr_data: got %0h expected 0", bus.mem_wr_data); else n_pass++;
    n_checks++; if (bus.cells_revealed !== 7'd0) $display("FAIL reset_cells: got %0d expected 0", bus.cells_revealed); else n_pass++;
  endtask

  task automatic test_single_reveal();
    int lat, bc, n_cnt; bit to;
    logic [9:0] got_w, want_w;
    logic [1:0] got_r;
    fill_img(4'hA); img[27] = 4'hB;
    load_board();
    exp_wr.push_back({6'd26, nb_bombs(2, 3)});
    exp_res.push_back(2'b00);
    do_reveal(3'd2, 3'd3, lat, bc, to);
    n_checks++; if (to !== 1'b0) $display("FAIL single_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (lat !== 15) $display("FAIL single_latency: got %0d expected 15", lat); else n_pass++;
    got_r = (obs_res.size() != 0) ? obs_res.pop_front() : 2'bxx;
    n_checks++; if (got_r !== exp_res[0]) $display("FAIL single_result: got %0b expected %0b", got_r, exp_res[0]); else n_pass++;
    n_cnt = 0; got_w = 'x;
    foreach (obs_wr[j]) if (obs_wr[j][3:0] != 4'hE) begin n_cnt++; got_w = obs_wr[j]; end
    want_w = exp_wr.pop_front();
    n_checks++; if (n_cnt !== 1) $display("FAIL single_nwrites: got %0d expected 1", n_cnt); else n_pass++;
    n_checks++; if (got_w !== want_w) $display("FAIL single_write: got addr %0d data %0h expected addr %0d data %0h", got_w[9:4], got_w[3:0], want_w[9:4], want_w[3:0]); else n_pass++;
    n_checks++; if (bus.cells_revealed !== 7'd1) $display("FAIL single_cells: got %0d expected 1", bus.cells_revealed); else n_pass++;
  endtask

  task automatic test_bomb();
    int lat, bc; bit to;
    logic [1:0] got_r, want_r;
    fill_img(4'hA); img[0] = 4'hB;
    load_board();
    exp_res.push_back(2'b01);
    do_reveal(3'd0, 3'd0, lat, bc, to);
    n_checks++; if (to !== 1'b0) $display("FAIL bomb_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (lat !== 3) $display("FAIL bomb_latency: got %0d expected 3", lat); else n_pass++;
    got_r = (obs_res.size() != 0) ? obs_res.pop_front() : 2'bxx;
    want_r = exp_res.pop_front();
    n_checks++; if (got_r !== want_r) $display("FAIL bomb_result: got %0b expected %0b", got_r, want_r); else n_pass++;
    n_checks++; if (obs_wr.size() !== 0) $display("FAIL bomb_writes: got %0d expected 0", obs_wr.size()); else n_pass++;
    n_checks++; if (bus.cells_revealed !== 7'd1) $display("FAIL bomb_cells: got %0d expected 1", bus.cells_revealed); else n_pass++;
  endtask

  task automatic test_ignored();
    int lat, bc; bit to;
    logic [1:0] got_r, want_r;
    logic [5:0] tgt [2];
    logic [3:0] code [2];
    tgt[0] = 6'd36; code[0] = 4'hC;
    tgt[1] = 6'd45; code[1] = 4'h2;
    for (int t = 0; t < 2; t++) begin
      fill_img(4'hA); img[tgt[t]] = code[t];
      load_board();
      exp_res.push_back(2'b10);
      do_reveal(tgt[t][2:0], tgt[t][5:3], lat, bc, to);
      got_r = (obs_res.size() != 0) ? obs_res.pop_front() : 2'bxx;
      want_r = exp_res.pop_front();
      n_checks++; if (got_r !== want_r) $display("FAIL ignored_result_%0d: got %0b expected %0b", t, got_r, want_r); else n_pass++;
      n_checks++; if (obs_wr.size() !== 0) $display("FAIL ignored_writes_%0d: got %0d expected 0", t, obs_wr.size()); else n_pass++;
      n_checks++; if (bc !== 2) $display("FAIL ignored_busy_%0d: got %0d expected 2", t, bc); else n_pass++;
      n_checks++; if (lat !== 3 || to) $display("FAIL ignored_latency_%0d: got %0d expected 3", t, lat); else n_pass++;
    end
  endtask

  task automatic test_flood();
    int lat, bc, exp_cells; bit to, found;
    logic [1:0] got_r, want_r;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    fill_img(4'hA); img[63] = 4'hB;
    load_board();
`ifdef REVEAL_FLOOD_FILL_EN
    for (int i = 0; i < 63; i++) exp_wr.push_back({6'(i), nb_bombs(i % 8, i / 8)});
    exp_cells = 63;
`else
    exp_wr.push_back({6'd0, nb_bombs(0, 0)});
    exp_cells = 1;
`endif
    exp_res.push_back(2'b00);
    do_reveal(3'd0, 3'd0, lat, bc, to);
    n_checks++; if (to !== 1'b0) $display("FAIL flood_timeout: got timeout expected done"); else n_pass++;
`ifndef REVEAL_FLOOD_FILL_EN
    n_checks++; if (lat !== 10) $display("FAIL flood_latency: got %0d expected 10", lat); else n_pass++;
`endif
    got_r = (obs_res.size() != 0) ? obs_res.pop_front() : 2'bxx;
    want_r = exp_res.pop_front();
    n_checks++; if (got_r !== want_r) $display("FAIL flood_result: got %0b expected %0b", got_r, want_r); else n_pass++;
    foreach (obs_wr[j]) if (obs_wr[j][3:0] != 4'hE) begin
      found = 1'b0;
      for (int k = 0; k < exp_wr.size(); k++) begin
        if (exp_wr[k] === obs_wr[j]) begin exp_wr.delete(k); found = 1'b1; break; end
      end
      n_checks++;
      if (!found) $display("FAIL flood_write: got addr %0d data %0h expected no such write", obs_wr[j][9:4], obs_wr[j][3:0]);
      else n_pass++;
    end
    n_checks++; if (exp_wr.size() !== 0) $display("FAIL flood_missing: got %0d unwritten expected 0", exp_wr.size()); else n_pass++;
    n_checks++; if (mem[63] !== 4'hB) $display("FAIL flood_bomb_cell: got %0h expected b", mem[63]); else n_pass++;
    n_checks++; if (bus.cells_revealed !== 7'(exp_cells)) $display("FAIL flood_cells: got %0d expected %0d", bus.cells_revealed, exp_cells); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, bc; bit to;
    logic [1:0] got_r, want_r;
    fill_img(4'hA); img[27] = 4'hB;
    load_board();
    @(negedge clk); bus.start = 1'b1; bus.start_x = 3'd2; bus.start_y = 3'd3;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %0b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.mem_wr_en !== 1'b0) $display("FAIL midrst_wr_en: got %0b expected 0", bus.mem_wr_en); else n_pass++;
    n_checks++; if (bus.cells_revealed !== 7'd0) $display("FAIL midrst_cells: got %0d expected 0", bus.cells_revealed); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL midrst_done: got %0b expected 0", bus.done); else n_pass++;
    @(negedge clk); rst = 1'b0;
    load_board();
    exp_res.push_back(2'b00);
    do_reveal(3'd2, 3'd3, lat, bc, to);
    got_r = (obs_res.size() != 0) ? obs_res.pop_front() : 2'bxx;
    want_r = exp_res.pop_front();
    n_checks++; if (got_r !== want_r || to) $display("FAIL midrst_restart_result: got %0b expected %0b", got_r, want_r); else n_pass++;
    n_checks++; if (bus.cells_revealed !== 7'd1) $display("FAIL midrst_restart_cells: got %0d expected 1", bus.cells_revealed); else n_pass++;
    n_checks++; if (mem[26] !== 4'h1) $display("FAIL midrst_restart_cell: got %0h expected 1", mem[26]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_reveal();
    test_bomb();
    test_ignored();
    test_flood();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
